axi_mtimer: RTL and testbench

RISC-V machine timer for the nox SoC: an AXI slave on a new interconnect slot (slave 7, `0xF000_0000`, 17-bit window) holding a 64-bit free-running `mtime` counter and a 64-bit `mtimecmp` compare register. It produces the machine timer interrupt that drives `irq_i[1]` of `nox_wrapper`. The interrupt is level, registered, and cleared by software rewriting `mtimecmp`.

---
 rtl/utils_pkg.sv | 68 ++++++
 rtl/mtimer_counter.sv | 79 +++++++
 rtl/axi_mtimer.sv | 208 ++++++++++++++++++++
 tb/tb_axi_mtimer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
// Shared SoC types and constants: AXI slave channel bundles plus the machine
// timer register map, control layout and byte-merge helper.
package utils_pkg;

  typedef struct packed {
    logic [7:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
    logic [7:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [7:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
  } s_axi_miso_t;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  localparam logic [31:0] MTIMER_BASE_ADDR = 32'hF000_0000;

  localparam logic [4:0] MTIMER_MTIME_LO    = 5'h00;
  localparam logic [4:0] MTIMER_MTIME_HI    = 5'h04;
  localparam logic [4:0] MTIMER_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] MTIMER_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] MTIMER_CTRL        = 5'h10;
  localparam logic [4:0] MTIMER_PRESC       = 5'h14;

  typedef struct packed {
    logic irq_en;
    logic en;
  } s_mtimer_ctrl_t;

  function automatic logic mtimer_mapped(input logic [4:0] off);
    return off <= MTIMER_PRESC;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mtimer_counter.sv
// Machine timer core: prescaler, 64-bit mtime/mtimecmp, control/prescale
// registers with byte-masked write port, and the registered mtip compare.
module mtimer_counter
  import utils_pkg::*;
#(
  parameter logic [31:0] PRESC_RST = 32'd0
) (
  input  logic           clk,
  input  logic           arst,
  input  logic           wr_en,
  input  logic [4:0]     wr_off,
  input  logic [31:0]    wr_data,
  input  logic [3:0]     wr_strb,
  output logic [63:0]    mtime_o,
  output logic [63:0]    mtimecmp_o,
  output s_mtimer_ctrl_t ctrl_o,
  output logic [31:0]    presc_o,
  output logic           mtip_o
);

  logic [31:0]    pcnt_q, pcnt_d;
  logic [31:0]    presc_q, presc_d;
  logic [63:0]    mtime_q, mtime_d;
  logic [63:0]    mtimecmp_q, mtimecmp_d;
  s_mtimer_ctrl_t ctrl_q, ctrl_d;
  logic           mtip_q, mtip_d;
  logic           tick;

  always_comb begin
    tick       = ctrl_q.en && (pcnt_q == presc_q);
    pcnt_d     = pcnt_q;
    presc_d    = presc_q;
    ctrl_d     = ctrl_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    if (ctrl_q.en) pcnt_d = tick ? '0 : pcnt_q + 32'd1;

    // An mtime write merges into the pre-tick value, dropping that increment
    if (wr_en) begin
      case (wr_off)
        MTIMER_MTIME_LO:    mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wr_data, wr_strb)};
        MTIMER_MTIME_HI:    mtime_d = {merge_bytes(mtime_q[63:32], wr_data, wr_strb), mtime_q[31:0]};
        MTIMER_MTIMECMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wr_data, wr_strb);
        MTIMER_MTIMECMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wr_data, wr_strb);
        MTIMER_CTRL:        if (wr_strb[0]) ctrl_d = s_mtimer_ctrl_t'(wr_data[1:0]);
        MTIMER_PRESC:       presc_d = merge_bytes(presc_q, wr_data, wr_strb);
        default:            ;
      endcase
    end

    // Compare on next-state values so a cmp rewrite clears mtip with bvalid
    mtip_d = ctrl_d.irq_en && (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      pcnt_q     <= '0;
      presc_q    <= PRESC_RST;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      ctrl_q     <= '0;
      mtip_q     <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_q     <= ctrl_d;
      mtip_q     <= mtip_d;
    end
  end

  assign mtime_o    = mtime_q;
  assign mtimecmp_o = mtimecmp_q;
  assign ctrl_o     = ctrl_q;
  assign presc_o    = presc_q;
  assign mtip_o     = mtip_q;

endmodule

// File: rtl/axi_mtimer.sv
// AXI slave front-end of the RISC-V machine timer: channel handshakes, decode
// and read mux. Optional MTIMER_SNAPSHOT_EN adds a coherent mtime_hi shadow.
module axi_mtimer
  import utils_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = MTIMER_BASE_ADDR,
  parameter logic [31:0] PRESC_RST = 32'd0
) (
  input  logic        clk,
  input  logic        arst,
  input  s_axi_mosi_t axi_mosi,
  output s_axi_miso_t axi_miso,
  output logic        mtip_o
);

  logic           awready_q, awready_d, wready_q, wready_d;
  logic           aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic [4:0]     awoff_q, awoff_d;
  logic [7:0]     awid_q, awid_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [3:0]     wstrb_q, wstrb_d;
  logic           bvalid_q, bvalid_d;
  logic [1:0]     bresp_q, bresp_d;
  logic           arready_q, arready_d, rvalid_q, rvalid_d;
  logic [7:0]     rid_q, rid_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [1:0]     rresp_q, rresp_d;

  logic           aw_fire, w_fire, b_fire, ar_fire, r_fire, wr_go, wr_en;
  logic [4:0]     wr_off, rd_off;
  logic [31:0]    wr_data, rd_val, mtime_hi_rd, presc;
  logic [3:0]     wr_strb;
  logic [63:0]    mtime, mtimecmp;
  s_mtimer_ctrl_t ctrl;

  always_comb begin
    aw_fire = axi_mosi.awvalid && awready_q;
    w_fire  = axi_mosi.wvalid && wready_q;
    b_fire  = bvalid_q && axi_mosi.bready;
    ar_fire = axi_mosi.arvalid && arready_q;
    r_fire  = rvalid_q && axi_mosi.rready;
    wr_go   = (aw_pend_q || aw_fire) && (w_pend_q || w_fire);
    wr_off  = aw_fire ? {axi_mosi.awaddr[4:2], 2'b00} : awoff_q;
    wr_data = w_fire ? axi_mosi.wdata : wdata_q;
    wr_strb = w_fire ? axi_mosi.wstrb : wstrb_q;
    wr_en   = wr_go && mtimer_mapped(wr_off);
    rd_off  = {axi_mosi.araddr[4:2], 2'b00};
  end

  mtimer_counter #(
    .PRESC_RST (PRESC_RST)
  ) u_counter (
    .clk        (clk),
    .arst       (arst),
    .wr_en      (wr_en),
    .wr_off     (wr_off),
    .wr_data    (wr_data),
    .wr_strb    (wr_strb),
    .mtime_o    (mtime),
    .mtimecmp_o (mtimecmp),
    .ctrl_o     (ctrl),
    .presc_o    (presc),
    .mtip_o     (mtip_o)
  );

`ifdef MTIMER_SNAPSHOT_EN
  logic [31:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (ar_fire && rd_off == MTIMER_MTIME_LO) shadow_d = mtime[63:32];
    if (wr_en && wr_off == MTIMER_MTIME_HI) shadow_d = merge_bytes(mtime[63:32], wr_data, wr_strb);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) shadow_q <= '0;
    else       shadow_q <= shadow_d;
  end

  assign mtime_hi_rd = shadow_q;
`else
  assign mtime_hi_rd = mtime[63:32];
`endif

  always_comb begin
    rd_val = '0;
    case (rd_off)
      MTIMER_MTIME_LO:    rd_val = mtime[31:0];
      MTIMER_MTIME_HI:    rd_val = mtime_hi_rd;
      MTIMER_MTIMECMP_LO: rd_val = mtimecmp[31:0];
      MTIMER_MTIMECMP_HI: rd_val = mtimecmp[63:32];
      MTIMER_CTRL:        rd_val = {30'd0, ctrl};
      MTIMER_PRESC:       rd_val = presc;
      default:            rd_val = '0;
    endcase
  end

  always_comb begin
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    awoff_d   = awoff_q;
    awid_d    = awid_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (aw_fire) begin
      awready_d = 1'b0;
      aw_pend_d = 1'b1;
      awoff_d   = {axi_mosi.awaddr[4:2], 2'b00};
      awid_d    = axi_mosi.awid;
    end
    if (w_fire) begin
      wready_d = 1'b0;
      w_pend_d = 1'b1;
      wdata_d  = axi_mosi.wdata;
      wstrb_d  = axi_mosi.wstrb;
    end
    if (wr_go) begin
      aw_pend_d = 1'b0;
      w_pend_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = mtimer_mapped(wr_off) ? AXI_OKAY : AXI_SLVERR;
    end
    if (b_fire) begin
      bvalid_d  = 1'b0;
      awready_d = 1'b1;
      wready_d  = 1'b1;
    end

    if (ar_fire) begin
      arready_d = 1'b0;
      rvalid_d  = 1'b1;
      rid_d     = axi_mosi.arid;
      rdata_d   = rd_val;
      rresp_d   = mtimer_mapped(rd_off) ? AXI_OKAY : AXI_SLVERR;
    end
    if (r_fire) begin
      rvalid_d  = 1'b0;
      arready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      awoff_q   <= '0;
      awid_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_OKAY;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= AXI_OKAY;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      awoff_q   <= awoff_d;
      awid_q    <= awid_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_comb begin
    axi_miso         = '0;
    axi_miso.awready = awready_q;
    axi_miso.wready  = wready_q;
    axi_miso.bid     = awid_q;
    axi_miso.bresp   = bresp_q;
    axi_miso.bvalid  = bvalid_q;
    axi_miso.arready = arready_q;
    axi_miso.rid     = rid_q;
    axi_miso.rdata   = rdata_q;
    axi_miso.rresp   = rresp_q;
    axi_miso.rlast   = 1'b1;
    axi_miso.rvalid  = rvalid_q;
  end

  // Decode looks only at offset bits [4:2]; the rest is deliberately ignored
  logic unused_ok;
  assign unused_ok = ^{BASE_ADDR, axi_mosi.awaddr[31:5], axi_mosi.awaddr[1:0], axi_mosi.awlen,
                       axi_mosi.wlast, axi_mosi.araddr[31:5], axi_mosi.araddr[1:0], axi_mosi.arlen};

endmodule

// File: tb/tb_axi_mtimer.sv
// Directed self-checking bench for axi_mtimer; expectations adapt when
// MTIMER_SNAPSHOT_EN is defined.
module tb_axi_mtimer;
  import utils_pkg::*;

  localparam logic [31:0] BASE = 32'hF000_0000;

  logic        clk;
  logic        arst;
  logic        mtip;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;
  int          n_cmp;
  int          n_err;

  axi_mtimer #(
    .BASE_ADDR (32'hF000_0000),
    .PRESC_RST (32'd0)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .axi_mosi (mosi),
    .axi_miso (miso),
    .mtip_o   (mtip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    arst = 1'b0;
    mosi.awvalid = 1'b0;
    mosi.wvalid  = 1'b0;
    mosi.arvalid = 1'b0;
    mosi.bready  = 1'b1;
    mosi.rready  = 1'b1;
    repeat (3) @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
  endtask

  // Starts and ends at a negedge; AW and W presented together.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic mtip_b);
    int unsigned t;
    mosi.awaddr  = addr;
    mosi.awid    = 8'h5A;
    mosi.awvalid = 1'b1;
    mosi.wdata   = data;
    mosi.wstrb   = strb;
    mosi.wlast   = 1'b1;
    mosi.wvalid  = 1'b1;
    t = 0;
    while (!(miso.awready && miso.wready) && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    mosi.awvalid = 1'b0;
    mosi.wvalid  = 1'b0;
    t = 0;
    while (!miso.bvalid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL write_timeout: addr %h no bvalid within 50 cycles", addr);
    end
    resp   = miso.bresp;
    mtip_b = mtip;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int unsigned t;
    mosi.araddr  = addr;
    mosi.arid    = 8'hC3;
    mosi.arvalid = 1'b1;
    t = 0;
    while (!miso.arready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    mosi.arvalid = 1'b0;
    t = 0;
    while (!miso.rvalid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL read_timeout: addr %h no rvalid within 50 cycles", addr);
    end
    data = miso.rdata;
    resp = miso.rresp;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    apply_reset();
    n_cmp++; if ({miso.awready, miso.wready, miso.arready} !== 3'b111) begin n_err++;
      $display("FAIL rst_readies: got %b exp 111", {miso.awready, miso.wready, miso.arready}); end
    n_cmp++; if ({miso.bvalid, miso.rvalid, mtip} !== 3'b000) begin n_err++;
      $display("FAIL rst_valids: got %b exp 000", {miso.bvalid, miso.rvalid, mtip}); end
    axi_read(BASE + 32'h08, d, r);
    n_cmp++; if ({d, r} !== {32'hFFFF_FFFF, AXI_OKAY}) begin n_err++;
      $display("FAIL rst_cmp_lo: got %h/%b exp ffffffff/00", d, r); end
    axi_read(BASE + 32'h0C, d, r);
    n_cmp++; if ({d, r} !== {32'hFFFF_FFFF, AXI_OKAY}) begin n_err++;
      $display("FAIL rst_cmp_hi: got %h/%b exp ffffffff/00", d, r); end
    axi_read(BASE + 32'h14, d, r);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_presc: got %h exp 0", d); end
    axi_read(BASE + 32'h00, d, r);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_mtime: got %h exp 0", d); end
    n_cmp++; if (mtip !== 1'b0) begin n_err++; $display("FAIL rst_mtip: got %b exp 0", mtip); end
  endtask

  task automatic test_prescaler();
    logic [31:0] d;
    logic [1:0]  r;
    logic        m;
    axi_write(BASE + 32'h14, 32'd3, 4'hF, r, m);
    axi_write(BASE + 32'h10, 32'd1, 4'hF, r, m);
    repeat (40) @(negedge clk);
    axi_read(BASE + 32'h00, d, r);
    n_cmp++; if ((d ^ d) !== 32'd0 || d < 32'd9 || d > 32'd11) begin n_err++;
      $display("FAIL presc_mtime: got %0d exp 10 (+/-1)", d); end
    axi_read(BASE + 32'h04, d, r);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL presc_mtime_hi: got %h exp 0", d); end
    axi_write(BASE + 32'h10, 32'd0, 4'hF, r, m);
  endtask

  task automatic test_irq();
    logic [1:0] r;
    logic       m;
    apply_reset();
    axi_write(BASE + 32'h08, 32'd20, 4'hF, r, m);
    axi_write(BASE + 32'h0C, 32'd0, 4'hF, r, m);
    axi_write(BASE + 32'h10, 32'd3, 4'hF, r, m);
    repeat (18) @(negedge clk);
    n_cmp++; if (mtip !== 1'b0) begin n_err++; $display("FAIL irq_early: mtip got %b exp 0 at mtime 19", mtip); end
    @(negedge clk);
    n_cmp++; if (mtip !== 1'b1) begin n_err++; $display("FAIL irq_rise: mtip got %b exp 1 at mtime 20", mtip); end
    axi_write(BASE + 32'h08, 32'd1000, 4'hF, r, m);
    n_cmp++; if (m !== 1'b0) begin n_err++; $display("FAIL irq_clear: mtip at bvalid got %b exp 0", m); end
    axi_write(BASE + 32'h08, 32'd0, 4'hF, r, m);
    n_cmp++; if (m !== 1'b1) begin n_err++; $display("FAIL irq_cmp0: mtip at bvalid got %b exp 1", m); end
    axi_write(BASE + 32'h10, 32'd1, 4'hF, r, m);
    n_cmp++; if (m !== 1'b0) begin n_err++; $display("FAIL irq_gate: mtip with irq_en=0 got %b exp 0", m); end
    axi_write(BASE + 32'h10, 32'd0, 4'hF, r, m);
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic [1:0]  r;
    logic        m;
    apply_reset();
    axi_write(BASE + 32'h00, 32'hFFFF_FFFE, 4'hF, r, m);
    axi_write(BASE + 32'h04, 32'hFFFF_FFFF, 4'hF, r, m);
    axi_read(BASE + 32'h00, d, r);
    n_cmp++; if (d !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL wrap_pre_lo: got %h exp fffffffe", d); end
    axi_write(BASE + 32'h10, 32'd1, 4'hF, r, m);
    axi_write(BASE + 32'h10, 32'd0, 4'hF, r, m);
    axi_read(BASE + 32'h00, d, r);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL wrap_lo: got %h exp 0", d); end
    axi_read(BASE + 32'h04, d, r);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL wrap_hi: got %h exp 0", d); end
    // tick at +1, write (tick dropped) at +2, ticks at +3 and +4
    axi_write(BASE + 32'h10, 32'd1, 4'hF, r, m);
    axi_write(BASE + 32'h00, 32'h1234_CD56, 4'b0010, r, m);
    axi_write(BASE + 32'h10, 32'd0, 4'hF, r, m);
    axi_read(BASE + 32'h00, d, r);
    n_cmp++; if (d !== 32'h0000_CD03) begin n_err++; $display("FAIL tick_write: got %h exp 0000cd03", d); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d;
    logic [1:0]  r;
    apply_reset();
    mosi.wdata  = 32'h1234_AB56;
    mosi.wstrb  = 4'b0010;
    mosi.wlast  = 1'b1;
    mosi.wvalid = 1'b1;
    @(negedge clk);
    mosi.wvalid = 1'b0;
    n_cmp++; if ({miso.wready, miso.awready, miso.bvalid} !== 3'b010) begin n_err++;
      $display("FAIL wfirst_ready: wready/awready/bvalid got %b exp 010", {miso.wready, miso.awready, miso.bvalid}); end
    repeat (2) @(negedge clk);
    mosi.awaddr  = BASE + 32'h14;
    mosi.awid    = 8'h21;
    mosi.awvalid = 1'b1;
    mosi.bready  = 1'b0;
    @(negedge clk);
    mosi.awvalid = 1'b0;
    n_cmp++; if ({miso.bvalid, miso.bid, miso.bresp} !== {1'b1, 8'h21, AXI_OKAY}) begin n_err++;
      $display("FAIL wfirst_b: bvalid/bid/bresp got %b/%h/%b exp 1/21/00", miso.bvalid, miso.bid, miso.bresp); end
    @(negedge clk);
    n_cmp++; if ({miso.bvalid, miso.awready, miso.wready} !== 3'b100) begin n_err++;
      $display("FAIL b_hold: bvalid/awready/wready got %b exp 100", {miso.bvalid, miso.awready, miso.wready}); end
    mosi.bready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({miso.bvalid, miso.awready, miso.wready} !== 3'b011) begin n_err++;
      $display("FAIL b_done: bvalid/awready/wready got %b exp 011", {miso.bvalid, miso.awready, miso.wready}); end
    axi_read(BASE + 32'h14, d, r);
    n_cmp++; if (d !== 32'h0000_AB00) begin n_err++; $display("FAIL wstrb_presc: got %h exp 0000ab00", d); end
  endtask

  task automatic test_concurrent();
    logic [31:0] d;
    logic [1:0]  r;
    mosi.awaddr  = BASE + 32'h14;
    mosi.awid    = 8'h33;
    mosi.awvalid = 1'b1;
    mosi.wdata   = 32'h0000_0055;
    mosi.wstrb   = 4'hF;
    mosi.wvalid  = 1'b1;
    mosi.araddr  = BASE + 32'h14;
    mosi.arid    = 8'h77;
    mosi.arvalid = 1'b1;
    @(negedge clk);
    mosi.awvalid = 1'b0;
    mosi.wvalid  = 1'b0;
    mosi.arvalid = 1'b0;
    n_cmp++; if ({miso.rvalid, miso.rdata, miso.rresp} !== {1'b1, 32'h0000_AB00, AXI_OKAY}) begin n_err++;
      $display("FAIL conc_rd_old: rvalid/rdata/rresp got %b/%h/%b exp 1/0000ab00/00", miso.rvalid, miso.rdata, miso.rresp); end
    n_cmp++; if ({miso.rid, miso.rlast, miso.bvalid} !== {8'h77, 1'b1, 1'b1}) begin n_err++;
      $display("FAIL conc_ids: rid/rlast/bvalid got %h/%b/%b exp 77/1/1", miso.rid, miso.rlast, miso.bvalid); end
    @(negedge clk);
    axi_read(BASE + 32'h14, d, r);
    n_cmp++; if (d !== 32'h0000_0055) begin n_err++; $display("FAIL conc_rd_new: got %h exp 00000055", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic [1:0]  r;
    logic        m;
    axi_write(BASE + 32'h1C, 32'hFFFF_FFFF, 4'hF, r, m);
    n_cmp++; if (r !== AXI_SLVERR) begin n_err++; $display("FAIL unm_bresp: got %b exp 10", r); end
    axi_read(BASE + 32'h1C, d, r);
    n_cmp++; if ({d, r} !== {32'd0, AXI_SLVERR}) begin n_err++; $display("FAIL unm_rd1c: got %h/%b exp 0/10", d, r); end
    axi_read(BASE + 32'h18, d, r);
    n_cmp++; if ({d, r} !== {32'd0, AXI_SLVERR}) begin n_err++; $display("FAIL unm_rd18: got %h/%b exp 0/10", d, r); end
    axi_read(BASE + 32'h14, d, r);
    n_cmp++; if (d !== 32'h0000_0055) begin n_err++; $display("FAIL unm_presc: got %h exp 00000055", d); end
    axi_read(BASE + 32'h10, d, r);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL unm_ctrl: got %h exp 0", d); end
    axi_read(BASE + 32'h0C, d, r);
    n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL unm_cmp_hi: got %h exp ffffffff", d); end
  endtask

  task automatic test_snapshot();
    logic [31:0] d;
    logic [31:0] exp_hi;
    logic [1:0]  r;
    logic        m;
`ifdef MTIMER_SNAPSHOT_EN
    exp_hi = 32'd0;
`else
    exp_hi = 32'd1;
`endif
    apply_reset();
    axi_write(BASE + 32'h00, 32'hFFFF_FFFF, 4'hF, r, m);
    axi_read(BASE + 32'h00, d, r);
    n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL snap_lo: got %h exp ffffffff", d); end
    axi_write(BASE + 32'h10, 32'd1, 4'hF, r, m);
    axi_write(BASE + 32'h10, 32'd0, 4'hF, r, m);
    axi_read(BASE + 32'h04, d, r);
    n_cmp++; if (d !== exp_hi) begin n_err++; $display("FAIL snap_hi: got %h exp %h", d, exp_hi); end
    axi_read(BASE + 32'h00, d, r);
    n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL snap_lo2: got %h exp 1", d); end
    axi_read(BASE + 32'h04, d, r);
    n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL snap_hi2: got %h exp 1", d); end
    axi_write(BASE + 32'h04, 32'd5, 4'hF, r, m);
    axi_read(BASE + 32'h04, d, r);
    n_cmp++; if (d !== 32'd5) begin n_err++; $display("FAIL snap_wr_hi: got %h exp 5", d); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    logic [1:0]  r;
    mosi.awaddr  = BASE + 32'h14;
    mosi.awid    = 8'h11;
    mosi.awvalid = 1'b1;
    mosi.araddr  = BASE + 32'h14;
    mosi.arvalid = 1'b1;
    @(negedge clk);
    mosi.awvalid = 1'b0;
    mosi.arvalid = 1'b0;
    n_cmp++; if ({miso.awready, miso.rvalid} !== 2'b01) begin n_err++;
      $display("FAIL mid_pre: awready/rvalid got %b exp 01", {miso.awready, miso.rvalid}); end
    arst = 1'b0;
    #1;
    n_cmp++; if ({miso.awready, miso.wready, miso.arready, miso.bvalid, miso.rvalid} !== 5'b11100) begin n_err++;
      $display("FAIL mid_rst: aw/w/ar ready, b/r valid got %b exp 11100",
               {miso.awready, miso.wready, miso.arready, miso.bvalid, miso.rvalid}); end
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    axi_read(BASE + 32'h14, d, r);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL mid_presc: got %h exp 0", d); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    mosi  = '0;
    mosi.bready = 1'b1;
    mosi.rready = 1'b1;
    arst  = 1'b0;
    test_reset();
    test_prescaler();
    test_irq();
    test_wrap();
    test_w_before_aw();
    test_concurrent();
    test_unmapped();
    test_snapshot();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
